// File: rtl/mem_stage_sram_pkg.sv
// Shared types and constants for the MEM-stage SRAM access unit.
// Two 16-bit SRAM half-word accesses make up one 32-bit pipeline word.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;
  localparam int          SRAM_DW       = 16;
  localparam int          WORD_W        = 32;
  // Wide enough for the largest legal WAIT_CYCLES (7).
  localparam int          CNT_W         = 3;

endpackage

// File: rtl/mem_stage_sram_if.sv
// External asynchronous SRAM bus: the controller is the master, the SRAM the slave.
interface mem_stage_sram_if
  import mem_stage_pkg::*;
#(
  parameter int SRAM_AW = 18
);
  logic [SRAM_AW-1:0] SRAM_ADDR;
  logic [SRAM_DW-1:0] SRAM_DQ_o;
  logic [SRAM_DW-1:0] SRAM_DQ_i;
  logic               SRAM_DQ_oe;
  logic               SRAM_WE_N;
  logic               SRAM_OE_N;

  modport master (
    output SRAM_ADDR, SRAM_DQ_o, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N,
    input  SRAM_DQ_i
  );

  modport slave (
    input  SRAM_ADDR, SRAM_DQ_o, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N,
    output SRAM_DQ_i
  );
endinterface

// File: rtl/mem_stage_sram_phase_timer.sv
// Per-phase wait counter; tc_o flags the last cycle of a half-word phase.
module sram_phase_timer
  import mem_stage_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/mem_stage_sram.sv
// MEM-stage data-memory unit: splits a 32-bit load/store into low then high
// 16-bit SRAM accesses and holds ready low while the access is in flight.
module mem_stage_sram
  import mem_stage_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
  parameter int          SRAM_AW     = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [WORD_W-1:0] ALU_result,
  input  logic [WORD_W-1:0] ST_val,
  output logic [WORD_W-1:0] Mem_R_value,
  output logic              ready,
  mem_stage_sram_if.master  sram
);
  state_e            state_q, state_d;
  logic              rd_q, rd_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              active, hi, req, tc;
  logic [WORD_W-1:0] offs;
  logic              unused_offs;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign active = (state_q == LOW) || (state_q == HIGH);
  assign hi     = (state_q == HIGH);

  // Modulo-2^32 offset: addresses below ADDR_BASE wrap, byte offset is dropped.
  assign offs        = ALU_result - ADDR_BASE;
  assign unused_offs = ^{offs[WORD_W-1:SRAM_AW+1], offs[1:0]};

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en_i  (active),
    .clr_i ((state_q == IDLE) || tc),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = LOW;
        // A simultaneous read and write is serviced as a read.
        rd_d    = MEM_R_EN;
      end
      LOW:  if (tc) state_d = HIGH;
      HIGH: if (tc) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rd_q && tc) begin
      if (hi) rdata_d[31:16] = sram.SRAM_DQ_i;
      else    rdata_d[15:0]  = sram.SRAM_DQ_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  assign Mem_R_value = rdata_q;
  assign ready       = ((state_q == IDLE) && !req) || (state_q == DONE);

  // WE_N releases on the last cycle of each phase for address/data hold,
  // except with no wait cycles where the single cycle must carry the strobe.
  always_comb begin
    sram.SRAM_ADDR  = '0;
    sram.SRAM_DQ_o  = '0;
    sram.SRAM_DQ_oe = 1'b0;
    sram.SRAM_WE_N  = 1'b1;
    sram.SRAM_OE_N  = 1'b1;
    if (active) begin
      sram.SRAM_ADDR = {offs[SRAM_AW:2], hi};
      if (rd_q) begin
        sram.SRAM_OE_N = 1'b0;
      end else begin
        sram.SRAM_DQ_oe = 1'b1;
        sram.SRAM_DQ_o  = hi ? ST_val[31:16] : ST_val[15:0];
        sram.SRAM_WE_N  = !(!tc || (WAIT_CYCLES == 0));
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances
// share stimulus; sel picks which instance is observed.
module tb_mem_stage_sram;
  logic        clk = 1'b0;
  logic        rst;
  logic        R, W;
  logic [31:0] ALU, ST;
  logic [31:0] rv1, rv0;
  logic        rdy1, rdy0;
  logic        sel;
  int          n_chk = 0;
  int          n_fail = 0;
  int          we_cnt1 = 0;
  int          we_snap;

  logic [15:0] mem1 [256];
  logic [15:0] mem0 [256];

  logic        o_ready, o_we_n, o_oe_n, o_dq_oe;
  logic [17:0] o_addr;
  logic [15:0] o_dq;
  logic [31:0] o_rv;

  always #5 clk = ~clk;

  mem_stage_sram_if #(.SRAM_AW(18)) sif1();
  mem_stage_sram_if #(.SRAM_AW(18)) sif0();

  mem_stage_sram #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024), .SRAM_AW(18)) u1 (
    .clk(clk), .rst(rst), .MEM_R_EN(R), .MEM_W_EN(W), .ALU_result(ALU), .ST_val(ST),
    .Mem_R_value(rv1), .ready(rdy1), .sram(sif1)
  );
  mem_stage_sram #(.WAIT_CYCLES(0), .ADDR_BASE(32'd1024), .SRAM_AW(18)) u0 (
    .clk(clk), .rst(rst), .MEM_R_EN(R), .MEM_W_EN(W), .ALU_result(ALU), .ST_val(ST),
    .Mem_R_value(rv0), .ready(rdy0), .sram(sif0)
  );

  // SRAM models: reset fills word i with 0xA500|i.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 16'hA500 | 16'(i);
    end else if (!sif1.SRAM_WE_N) begin
      mem1[sif1.SRAM_ADDR[7:0]] <= sif1.SRAM_DQ_o;
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 256; j++) mem0[j] <= 16'hA500 | 16'(j);
    end else if (!sif0.SRAM_WE_N) begin
      mem0[sif0.SRAM_ADDR[7:0]] <= sif0.SRAM_DQ_o;
    end
  end
  always @(posedge clk) if (!sif1.SRAM_WE_N) we_cnt1 <= we_cnt1 + 1;

  assign sif1.SRAM_DQ_i = sif1.SRAM_OE_N ? 16'h0000 : mem1[sif1.SRAM_ADDR[7:0]];
  assign sif0.SRAM_DQ_i = sif0.SRAM_OE_N ? 16'h0000 : mem0[sif0.SRAM_ADDR[7:0]];

  always_comb begin
    o_ready = sel ? rdy0            : rdy1;
    o_we_n  = sel ? sif0.SRAM_WE_N  : sif1.SRAM_WE_N;
    o_oe_n  = sel ? sif0.SRAM_OE_N  : sif1.SRAM_OE_N;
    o_dq_oe = sel ? sif0.SRAM_DQ_oe : sif1.SRAM_DQ_oe;
    o_addr  = sel ? sif0.SRAM_ADDR  : sif1.SRAM_ADDR;
    o_dq    = sel ? sif0.SRAM_DQ_o  : sif1.SRAM_DQ_o;
    o_rv    = sel ? rv0             : rv1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"},  32'(o_ready), 32'd1);
    chk({tag, "_we"},   32'(o_we_n),  32'd1);
    chk({tag, "_oe"},   32'(o_oe_n),  32'd1);
    chk({tag, "_dqoe"}, 32'(o_dq_oe), 32'd0);
  endtask

  // One access from IDLE: request cycle, 2*(w+1) busy cycles, then DONE.
  task automatic access(input bit rd, input logic [31:0] a, input logic [31:0] st,
                        input logic [17:0] sa, input int w, input logic [31:0] exp_rd);
    logic hi, last;
    @(negedge clk);
    R = rd; W = !rd; ALU = a; ST = st;
    #1 chk("rdy_req", 32'(o_ready), 32'd0);
    for (int c = 1; c <= 2 * (w + 1); c++) begin
      @(negedge clk); #1;
      hi   = (c - 1) > w;
      last = ((c - 1) % (w + 1)) == w;
      chk("rdy_busy", 32'(o_ready), 32'd0);
      chk("addr", 32'(o_addr), 32'({sa[17:1], hi}));
      if (rd) begin
        chk("rd_oe_n", 32'(o_oe_n),  32'd0);
        chk("rd_we_n", 32'(o_we_n),  32'd1);
        chk("rd_dqoe", 32'(o_dq_oe), 32'd0);
      end else begin
        chk("wr_dqoe", 32'(o_dq_oe), 32'd1);
        chk("wr_dq",   32'(o_dq),    32'(hi ? st[31:16] : st[15:0]));
        chk("wr_we_n", 32'(o_we_n),  32'(last && (w != 0)));
      end
    end
    @(negedge clk); #1;
    chk_idle("done");
    if (rd) chk("rdval", o_rv, exp_rd);
    R = 1'b0; W = 1'b0;
  endtask

  initial begin
    rst = 1'b1; R = 1'b0; W = 1'b0; ALU = '0; ST = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 chk_idle("reset");
    chk("reset_rv",   o_rv, 32'h0);
    chk("reset_addr", 32'(o_addr), 32'h0);

    // Store then load, WAIT_CYCLES=1.
    access(1'b0, 32'd1032, 32'hDEADBEEF, 18'd4, 1, 32'h0);
    chk("wr_keeps_rv", o_rv, 32'h0);
    access(1'b1, 32'd1032, 32'h0, 18'd4, 1, 32'hDEADBEEF);

    // Back-to-back loads, next request arrives in IDLE right after DONE.
    access(1'b1, 32'd1028, 32'h0, 18'd2, 1, 32'hA503A502);
    access(1'b1, 32'd1032, 32'h0, 18'd4, 1, 32'hDEADBEEF);
    @(negedge clk); #1 chk_idle("post_b2b");
    chk("hold_rv", o_rv, 32'hDEADBEEF);

    // Below ADDR_BASE wraps: word 0x3FFFFF00 -> half-word address 0x3FE00.
    access(1'b1, 32'd0, 32'h0, 18'h3FE00, 1, 32'hA501A500);

    // Both enables: serviced as a read, SRAM untouched.
    @(negedge clk);
    R = 1'b1; W = 1'b1; ALU = 32'd1028; ST = 32'h11112222;
    @(negedge clk); #1;
    chk("both_oe_n", 32'(o_oe_n), 32'd0);
    chk("both_we_n", 32'(o_we_n), 32'd1);
    R = 1'b0; W = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("both_rv", o_rv, 32'hA503A502);

    // Reset during the HIGH phase of a store aborts it.
    @(negedge clk);
    W = 1'b1; ALU = 32'd1040; ST = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    #1 chk("mid_addr", 32'(o_addr), 32'd9);
    chk("mid_we_n", 32'(o_we_n), 32'd0);
    rst = 1'b1; W = 1'b0;
    @(negedge clk); #1;
    chk_idle("rst_mid");
    chk("rst_mid_rv",   o_rv, 32'h0);
    chk("rst_mid_addr", 32'(o_addr), 32'h0);
    we_snap = we_cnt1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("no_strobe", 32'(we_cnt1), 32'(we_snap));

    // WAIT_CYCLES=0 instance.
    sel = 1'b1;
    #1 chk_idle("w0_idle");
    access(1'b0, 32'd1088, 32'h13572468, 18'h20, 0, 32'h0);
    access(1'b1, 32'd1088, 32'h0, 18'h20, 0, 32'h13572468);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
